rtl_divider_sched: RTL and testbench

- Round-robin scheduler that shares one multi-cycle rtl_divider datapath core among NUM_REQ requesters.
- Accepts {dividend, divisor} jobs over per-requester valid/ready, sequences the core through start/done, and returns quotient, remainder and status on a shared response bus with a one-hot valid.
- Handles divide-by-zero without touching the core, and aborts on a watchdog timeout.
- Sits between the AXI-lite register front-ends and the divider core.

---
 rtl/rtl_divider_sched.sv | 168 ++++++++++++++++
 tb/tb_rtl_divider_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtl_divider_sched.sv
// rtl_divider_sched
// Round-robin scheduler that shares one multi-cycle divider core among
// NUM_REQ requesters. Each requester offers a {dividend, divisor} job over
// valid/ready. The scheduler runs the core through start/done and returns
// quotient, remainder and status on a shared response bus with a one-hot
// valid. Only one job is in flight at a time.
//
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   req_valid/ready     per-requester job handshake
//   req_dividend/divisor packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid/ready     one-hot response valid, per-requester accept
//   rsp_quotient/remainder/err  shared result (err: 00 ok, 01 div-by-zero, 10 timeout)
//   busy                high whenever a job is being handled
//   div_start/abort     one-cycle control pulses to the core
//   div_dividend/divisor operands to the core, held for the whole job
//   div_done/quotient/remainder  core completion and results
module rtl_divider_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_quotient,
  output logic [DATA_WIDTH-1:0]           rsp_remainder,
  output logic [1:0]                      rsp_err,
  output logic                            busy,
  output logic                            div_start,
  output logic                            div_abort,
  output logic [DATA_WIDTH-1:0]           div_dividend,
  output logic [DATA_WIDTH-1:0]           div_divisor,
  input  logic                            div_done,
  input  logic [DATA_WIDTH-1:0]           div_quotient,
  input  logic [DATA_WIDTH-1:0]           div_remainder
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          gnt_idx;
  logic [TW-1:0]          timer;

  logic                   arb_hit;
  logic [PW-1:0]          arb_idx;
  logic [PW:0]            scan_idx;
  logic [DATA_WIDTH-1:0]  sel_dividend;
  logic [DATA_WIDTH-1:0]  sel_divisor;
  logic                   timeout_hit;

  // Round-robin arbiter: scan from ptr upward, wrapping modulo NUM_REQ.
  // The loop runs downward so the closest requester to ptr wins last.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr} + (PW+1)'(k);
      if (scan_idx >= (PW+1)'(NUM_REQ))
        scan_idx = scan_idx - (PW+1)'(NUM_REQ);
      if (req_valid[scan_idx[PW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = scan_idx[PW-1:0];
      end
    end
  end

  // Operand select for the winning requester.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == PW'(i)) begin
        sel_dividend = req_dividend[i*DATA_WIDTH +: DATA_WIDTH];
        sel_divisor  = req_divisor[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // req_ready is masked during reset so every output reads 0 while ARESET is high.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && arb_hit && !ARESET)
      req_ready = NUM_REQ'(1) << arb_idx;
  end

  // A completion in the timeout cycle takes priority over the abort.
  assign timeout_hit = (state == WAIT) && !div_done && (timer == TMO_LAST);

  assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign busy      = (state != IDLE);
  assign div_start = (state == ISSUE) && (div_divisor != '0);
  assign div_abort = timeout_hit;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= IDLE;
      ptr           <= '0;
      gnt_idx       <= '0;
      timer         <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_err       <= ERR_OK;
      div_dividend  <= '0;
      div_divisor   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_hit) begin
            gnt_idx      <= arb_idx;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // A zero divisor never reaches the core.
          if (div_divisor == '0) begin
            rsp_quotient  <= '1;
            rsp_remainder <= div_dividend;
            rsp_err       <= ERR_DIV0;
            state         <= RESP;
          end else begin
            timer <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_err       <= ERR_OK;
            state         <= RESP;
          end else if (timeout_hit) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_err       <= ERR_TMO;
            state         <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[gnt_idx]) begin
            ptr   <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtl_divider_sched.sv
module tb_rtl_divider_sched;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TMO = 64;

  logic           ACLK = 1'b0;
  logic           ARESET;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_dividend, req_divisor;
  logic [W-1:0]   rsp_quotient, rsp_remainder;
  logic [1:0]     rsp_err;
  logic           busy, div_start, div_abort, div_done;
  logic [W-1:0]   div_dividend, div_divisor, div_quotient, div_remainder;

  int n_cmp = 0;
  int n_err = 0;

  rtl_divider_sched #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .busy(busy), .div_start(div_start), .div_abort(div_abort),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_job(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    req_valid = 4'b1111; rsp_ready = '0; req_dividend = '0; req_divisor = '0;
    div_done = 1'b0; div_quotient = '0; div_remainder = '0;
    step();
    n_cmp++;
    if ({req_ready, rsp_valid, busy, div_start, div_abort} !== 11'd0) begin
      n_err++; $display("FAIL reset_ctrl got %b required 0", {req_ready, rsp_valid, busy, div_start, div_abort});
    end
    n_cmp++;
    if ({rsp_quotient, rsp_remainder, rsp_err, div_dividend, div_divisor} !== '0) begin
      n_err++; $display("FAIL reset_data got q=%h r=%h e=%b dd=%h dv=%h required 0", rsp_quotient, rsp_remainder, rsp_err, div_dividend, div_divisor);
    end
    ARESET = 1'b0;
    req_valid = '0;
    step();
  endtask

  task automatic test_single();
    set_job(0, 100, 7);
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_req_ready got %b required 0001", req_ready); end
    step();
    req_valid = '0;
    n_cmp++;
    if ({div_start, div_dividend, div_divisor} !== {1'b1, 32'd100, 32'd7}) begin
      n_err++; $display("FAIL single_start got start=%b dd=%0d dv=%0d required 1/100/7", div_start, div_dividend, div_divisor);
    end
    for (int c = 1; c < 32; c++) begin
      step();
      n_cmp++;
      if ({div_start, rsp_valid, busy} !== 6'b000001) begin
        n_err++; $display("FAIL single_wait cycle %0d got start=%b rsp_valid=%b busy=%b required 0/0000/1", c, div_start, rsp_valid, busy);
      end
    end
    step();
    div_done = 1'b1; div_quotient = 14; div_remainder = 2;
    #1;
    n_cmp++;
    if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_done_cycle got rsp_valid=%b required 0000", rsp_valid); end
    step();
    div_done = 1'b0; div_quotient = '0; div_remainder = '0;
    n_cmp++;
    if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== {4'b0001, 32'd14, 32'd2, 2'b00}) begin
      n_err++; $display("FAIL single_rsp got v=%b q=%0d r=%0d e=%b required 0001/14/2/00", rsp_valid, rsp_quotient, rsp_remainder, rsp_err);
    end
    rsp_ready = 4'b0001;
    step();
    rsp_ready = '0;
    n_cmp++;
    if ({rsp_valid, busy} !== 5'b00000) begin n_err++; $display("FAIL single_idle got v=%b busy=%b required 0000/0", rsp_valid, busy); end
  endtask

  // Pointer is 1 here, so requester 2 wins as the only valid line.
  task automatic test_div_zero();
    set_job(2, 32'h1234, 0);
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_err++; $display("FAIL dz_req_ready got %b required 0100", req_ready); end
    step();
    req_valid = '0;
    n_cmp++;
    if ({div_start, busy, rsp_valid} !== 6'b010000) begin
      n_err++; $display("FAIL dz_issue got start=%b busy=%b v=%b required 0/1/0000", div_start, busy, rsp_valid);
    end
    step();
    n_cmp++;
    if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err, div_start} !== {4'b0100, 32'hFFFF_FFFF, 32'h1234, 2'b01, 1'b0}) begin
      n_err++; $display("FAIL dz_rsp got v=%b q=%h r=%h e=%b start=%b required 0100/ffffffff/1234/01/0", rsp_valid, rsp_quotient, rsp_remainder, rsp_err, div_start);
    end
    // A stray completion outside WAIT must not disturb the response.
    div_done = 1'b1; div_quotient = 32'hDEAD; div_remainder = 32'hBEEF;
    step();
    div_done = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== {4'b0100, 32'hFFFF_FFFF, 32'h1234, 2'b01}) begin
      n_err++; $display("FAIL dz_stray_done got v=%b q=%h r=%h e=%b required 0100/ffffffff/1234/01", rsp_valid, rsp_quotient, rsp_remainder, rsp_err);
    end
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
  endtask

  task automatic test_round_robin();
    ARESET = 1'b1; #1; ARESET = 1'b0;
    step();
    for (int i = 0; i < N; i++) set_job(i, 10, 3);
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      logic [N-1:0] exp_g;
      exp_g = 4'b0001 << (j % N);
      #1;
      n_cmp++;
      if (req_ready !== exp_g) begin n_err++; $display("FAIL rr_grant job %0d got %b required %b", j, req_ready, exp_g); end
      step();
      n_cmp++;
      if ({req_ready, div_start} !== 5'b00001) begin n_err++; $display("FAIL rr_issue job %0d got ready=%b start=%b required 0000/1", j, req_ready, div_start); end
      step();
      div_done = 1'b1; div_quotient = 3; div_remainder = 1;
      step();
      div_done = 1'b0;
      n_cmp++;
      if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== {exp_g, 32'd3, 32'd1, 2'b00}) begin
        n_err++; $display("FAIL rr_rsp job %0d got v=%b q=%0d r=%0d e=%b required %b/3/1/00", j, rsp_valid, rsp_quotient, rsp_remainder, rsp_err, exp_g);
      end
      rsp_ready = 4'b1111;
      step();
      rsp_ready = '0;
    end
    req_valid = '0;
  endtask

  // Pointer is 1 after the round-robin run; first job from req 1, second from req 2.
  task automatic test_timeout();
    set_job(1, 50, 5);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    n_cmp++;
    if (div_start !== 1'b1) begin n_err++; $display("FAIL tmo_start got %b required 1", div_start); end
    for (int k = 1; k < TMO; k++) begin
      step();
      n_cmp++;
      if ({div_abort, rsp_valid} !== 5'b00000) begin n_err++; $display("FAIL tmo_early cycle %0d got abort=%b v=%b required 0/0000", k, div_abort, rsp_valid); end
    end
    step();
    n_cmp++;
    if (div_abort !== 1'b1) begin n_err++; $display("FAIL tmo_abort got %b required 1", div_abort); end
    step();
    n_cmp++;
    if ({div_abort, rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== {1'b0, 4'b0010, 32'd0, 32'd0, 2'b10}) begin
      n_err++; $display("FAIL tmo_rsp got abort=%b v=%b q=%0d r=%0d e=%b required 0/0010/0/0/10", div_abort, rsp_valid, rsp_quotient, rsp_remainder, rsp_err);
    end
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;

    set_job(2, 50, 5);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    for (int k = 1; k < TMO; k++) step();
    div_done = 1'b1; div_quotient = 10; div_remainder = 0;
    #1;
    n_cmp++;
    if (div_abort !== 1'b0) begin n_err++; $display("FAIL tmo_race_abort got %b required 0", div_abort); end
    step();
    div_done = 1'b0;
    n_cmp++;
    if ({div_abort, rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== {1'b0, 4'b0100, 32'd10, 32'd0, 2'b00}) begin
      n_err++; $display("FAIL tmo_race_rsp got abort=%b v=%b q=%0d r=%0d e=%b required 0/0100/10/0/00", div_abort, rsp_valid, rsp_quotient, rsp_remainder, rsp_err);
    end
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
  endtask

  // Pointer is 3 here; only requester 1 is valid, so it is granted.
  task automatic test_backpressure_reset();
    set_job(1, 20, 6);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    div_done = 1'b1; div_quotient = 3; div_remainder = 2;
    step();
    div_done = 1'b0; div_quotient = '0; div_remainder = '0;
    req_valid = 4'b1111;
    rsp_ready = 4'b1101;
    for (int c = 0; c < 20; c++) begin
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err, req_ready} !== {4'b0010, 32'd3, 32'd2, 2'b00, 4'b0000}) begin
        n_err++; $display("FAIL bp_hold cycle %0d got v=%b q=%0d r=%0d e=%b ready=%b required 0010/3/2/00/0000", c, rsp_valid, rsp_quotient, rsp_remainder, rsp_err, req_ready);
      end
      step();
    end
    req_valid = '0;
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    n_cmp++;
    if ({rsp_valid, busy} !== 5'b00000) begin n_err++; $display("FAIL bp_release got v=%b busy=%b required 0000/0", rsp_valid, busy); end

    // Job into WAIT, then reset mid-flight.
    set_job(0, 77, 7);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    step();
    ARESET = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, busy, div_start, div_abort, rsp_quotient, rsp_remainder, rsp_err, div_dividend, div_divisor} !== '0) begin
      n_err++; $display("FAIL rst_mid got ready=%b v=%b busy=%b start=%b abort=%b dd=%0d required all 0", req_ready, rsp_valid, busy, div_start, div_abort, div_dividend);
    end
    step();
    ARESET = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_ptr got ready=%b required 0001", req_ready); end
    set_job(3, 9, 4);
    req_valid = 4'b1000;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin n_err++; $display("FAIL post_rst_grant got %b required 1000", req_ready); end
    step();
    req_valid = '0;
    n_cmp++;
    if ({div_start, div_dividend, div_divisor} !== {1'b1, 32'd9, 32'd4}) begin
      n_err++; $display("FAIL post_rst_start got start=%b dd=%0d dv=%0d required 1/9/4", div_start, div_dividend, div_divisor);
    end
    step();
    step();
    div_done = 1'b1; div_quotient = 2; div_remainder = 1;
    step();
    div_done = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== {4'b1000, 32'd2, 32'd1, 2'b00}) begin
      n_err++; $display("FAIL post_rst_rsp got v=%b q=%0d r=%0d e=%b required 1000/2/1/00", rsp_valid, rsp_quotient, rsp_remainder, rsp_err);
    end
    rsp_ready = 4'b1000;
    step();
    rsp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_div_zero();
    test_round_robin();
    test_timeout();
    test_backpressure_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
